// File: rtl/logic_pipe.sv
// logic_pipe: handshaked two-operand bitwise pipeline of DEPTH register stages.
// Each accepted (a, b) pair is combined by op (OR/AND/XOR/pass-A) and carried
// through DEPTH stages to q. Empty stages are filled from behind, so gaps between
// items close up. A stall at the output only holds back stages that are occupied.
// Ports:
//   clk, res           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake (in_ready is combinational)
//   a, b, op           operands and operation select
//   out_valid/out_ready output handshake (out_valid registered)
//   q                  result at the last stage (registered)
//   occupancy          number of valid stages (registered)
module logic_pipe #(
  parameter  int unsigned WIDTH = 1,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    occupancy
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [CW-1:0]               occ_q, occ_d;
  logic [WIDTH-1:0]            op_res;
  logic                        accept;
  logic                        drain;

  // Bitwise operation on the incoming operands.
  always_comb begin
    op_res = a | b;
    case (op)
      2'b00:   op_res = a | b;
      2'b01:   op_res = a & b;
      2'b10:   op_res = a ^ b;
      default: op_res = a;
    endcase
  end

  // A stage can advance when the output drains or any later stage is empty;
  // computed per stage without a chained vector to keep the logic acyclic.
  always_comb begin
    logic hole;
    adv  = '0;
    load = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hole = 1'b0;
      for (int unsigned j = i + 1; j < DEPTH; j++) begin
        hole = hole | !v_q[j];
      end
      adv[i]  = out_ready | hole;
      load[i] = !v_q[i] | adv[i];
    end
  end

  assign in_ready = !res && load[0];
  assign accept   = in_valid && in_ready;
  assign drain    = v_q[DEPTH-1] && out_ready;

  // Next-state for data, valid and occupancy.
  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    occ_d  = occ_q + CW'(accept) - CW'(drain);
    if (load[0]) begin
      data_d[0] = op_res;
      v_d[0]    = accept;
    end
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        data_d[i] = data_q[i-1];
        v_d[i]    = v_q[i-1];
      end
    end
  end

  // State registers; reset discards all in-flight items.
  always_ff @(posedge clk) begin
    if (res) begin
      data_q <= '0;
      v_q    <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
      occ_q  <= occ_d;
    end
  end

  assign q         = data_q[DEPTH-1];
  assign out_valid = v_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_logic_pipe.sv
// Testbench for logic_pipe: a DEPTH=2 instance for the operation/latency check
// and a DEPTH=4 instance checked against a queue model of in-flight items.
module tb_logic_pipe;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic       iv2, ir2, ov2, or2;
  logic [7:0] a2, b2, q2;
  logic [1:0] op2;
  logic [1:0] occ2;

  // DEPTH=4 instance signals
  logic       iv, ir, ov, ordy;
  logic [7:0] a, b, q;
  logic [1:0] op;
  logic [2:0] occ;

  int checks = 0;
  int errors = 0;

  logic_pipe #(.WIDTH(8), .DEPTH(2)) dut2 (
    .clk(clk), .res(res), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .op(op2),
    .out_valid(ov2), .out_ready(or2), .q(q2), .occupancy(occ2)
  );

  logic_pipe #(.WIDTH(8), .DEPTH(D)) dut4 (
    .clk(clk), .res(res), .in_valid(iv), .in_ready(ir), .a(a), .b(b), .op(op),
    .out_valid(ov), .out_ready(ordy), .q(q), .occupancy(occ)
  );

  // Reference model: ordered list of in-flight results with their age in edges.
  // The head is unobstructed, so it reaches the output after DEPTH-1 edges.
  typedef struct {
    logic [7:0]  d;
    int unsigned age;
  } item_t;
  item_t m_q[$];

  function automatic logic [7:0] f_op(input logic [7:0] x, input logic [7:0] y,
                                      input logic [1:0] o);
    case (o)
      2'd0:    return x | y;
      2'd1:    return x & y;
      2'd2:    return x ^ y;
      default: return x;
    endcase
  endfunction

  function automatic logic m_valid();
    return (m_q.size() > 0) && (m_q[0].age >= D - 1);
  endfunction

  // Collapsing stages leave room for a new item whenever fewer than DEPTH are held.
  function automatic logic m_ready();
    return !res && (ordy || (m_q.size() < D));
  endfunction

  // Advance one clock edge, updating the model from the pre-edge inputs.
  task automatic tick();
    logic       acc, pop, rs;
    logic [7:0] r;
    item_t      it;
    acc = iv && m_ready();
    pop = m_valid() && ordy;
    rs  = res;
    r   = f_op(a, b, op);
    @(posedge clk);
    if (rs) begin
      m_q.delete();
    end else begin
      if (pop) void'(m_q.pop_front());
      for (int i = 0; i < m_q.size(); i++) m_q[i].age = m_q[i].age + 1;
      if (acc) begin
        it.d   = r;
        it.age = 0;
        m_q.push_back(it);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    iv2 = 1'b1; a2 = 8'hFF; b2 = 8'h0F; op2 = 2'd0; or2 = 1'b1;
    iv  = 1'b1; a  = 8'hFF; b  = 8'h0F; op  = 2'd0; ordy = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL rst_ov2: got %0b want 0", ov2); end
      checks++; if (q2 !== 8'h00) begin errors++; $display("FAIL rst_q2: got %0h want 0", q2); end
      checks++; if (occ2 !== 2'd0) begin errors++; $display("FAIL rst_occ2: got %0d want 0", occ2); end
      checks++; if (ir2 !== 1'b0) begin errors++; $display("FAIL rst_ir2: got %0b want 0", ir2); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL rst_ov: got %0b want 0", ov); end
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL rst_q: got %0h want 0", q); end
      checks++; if (occ !== 3'd0) begin errors++; $display("FAIL rst_occ: got %0d want 0", occ); end
      checks++; if (ir !== 1'b0) begin errors++; $display("FAIL rst_ir: got %0b want 0", ir); end
      tick();
    end
    res = 1'b0; iv2 = 1'b0; iv = 1'b0; ordy = 1'b0;
    #1;
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL rst_rel_ir2: got %0b want 1", ir2); end
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL rst_rel_ir: got %0b want 1", ir); end
  endtask

  task automatic test_ops();
    logic [7:0] exp_q [4];
    logic [1:0] exp_occ;
    exp_q[0] = 8'hEE; exp_q[1] = 8'h88; exp_q[2] = 8'h66; exp_q[3] = 8'hCC;
    or2 = 1'b1; a2 = 8'hCC; b2 = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      iv2 = (k < 4);
      op2 = 2'(k);
      #1;
      if (k < 4) begin
        checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL ops_ir k=%0d: got %0b want 1", k, ir2); end
      end
      tick();
      exp_occ = (k == 0 || k == 4) ? 2'd1 : 2'd2;
      checks++; if (occ2 !== exp_occ) begin errors++; $display("FAIL ops_occ k=%0d: got %0d want %0d", k, occ2, exp_occ); end
      if (k == 0) begin
        checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL ops_lat: got ov %0b want 0", ov2); end
      end else begin
        checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL ops_ov k=%0d: got %0b want 1", k, ov2); end
        checks++; if (q2 !== exp_q[k-1]) begin errors++; $display("FAIL ops_q k=%0d: got %0h want %0h", k, q2, exp_q[k-1]); end
      end
    end
    iv2 = 1'b0;
    tick();
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL ops_empty: got ov %0b want 0", ov2); end
  endtask

  task automatic test_backpressure();
    int n_acc, n_out;
    n_acc = 0; n_out = 0;
    ordy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      iv = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      #1;
      checks++; if (ir !== m_ready()) begin errors++; $display("FAIL bp_ir k=%0d: got %0b want %0b", k, ir, m_ready()); end
      if (ir === 1'b1) n_acc++;
      tick();
      checks++; if (occ !== 3'(m_q.size())) begin errors++; $display("FAIL bp_occ k=%0d: got %0d want %0d", k, occ, m_q.size()); end
      if (m_valid()) begin
        checks++; if (q !== m_q[0].d) begin errors++; $display("FAIL bp_hold_q: got %0h want %0h", q, m_q[0].d); end
      end
    end
    checks++; if (n_acc != 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", n_acc); end
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL bp_full_occ: got %0d want 4", occ); end
    checks++; if (ir !== 1'b0) begin errors++; $display("FAIL bp_full_ir: got %0b want 0", ir); end
    iv = 1'b0; ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (ov !== m_valid()) begin errors++; $display("FAIL bp_drain_ov k=%0d: got %0b want %0b", k, ov, m_valid()); end
      if (m_valid()) begin
        n_out++;
        checks++; if (q !== m_q[0].d) begin errors++; $display("FAIL bp_drain_q k=%0d: got %0h want %0h", k, q, m_q[0].d); end
      end
      tick();
    end
    checks++; if (n_out != 4) begin errors++; $display("FAIL bp_emitted: got %0d want 4", n_out); end
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL bp_end_occ: got %0d want 0", occ); end
    ordy = 1'b0;
  endtask

  task automatic test_bubble();
    logic [7:0] ia, ib;
    ordy = 1'b0;
    iv = 1'b1; a = 8'h5A; b = 8'($urandom); op = 2'd3; ia = 8'h5A;
    tick();
    iv = 1'b0;
    tick(); tick();
    iv = 1'b1; a = 8'hA5; b = 8'($urandom); op = 2'd3; ib = 8'hA5;
    tick();
    iv = 1'b0;
    repeat (4) tick();
    checks++; if (occ !== 3'd2) begin errors++; $display("FAIL bub_occ: got %0d want 2", occ); end
    checks++; if (ov !== 1'b1 || q !== ia) begin errors++; $display("FAIL bub_head: got ov %0b q %0h want 1 %0h", ov, q, ia); end
    checks++; if (ir !== 1'b1) begin errors++; $display("FAIL bub_ir: got %0b want 1", ir); end
    ordy = 1'b1;
    tick();
    checks++; if (ov !== 1'b1 || q !== ib) begin errors++; $display("FAIL bub_next: got ov %0b q %0h want 1 %0h", ov, q, ib); end
    checks++; if (occ !== 3'd1) begin errors++; $display("FAIL bub_occ1: got %0d want 1", occ); end
    tick();
    checks++; if (ov !== 1'b0 || occ !== 3'd0) begin errors++; $display("FAIL bub_empty: got ov %0b occ %0d want 0 0", ov, occ); end
    ordy = 1'b0;
  endtask

  task automatic test_back_to_back();
    ordy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      iv = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      tick();
    end
    checks++; if (occ !== 3'd4) begin errors++; $display("FAIL b2b_fill: got %0d want 4", occ); end
    ordy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      #1;
      checks++; if (ir !== 1'b1) begin errors++; $display("FAIL b2b_ir k=%0d: got %0b want 1", k, ir); end
      checks++; if (ov !== 1'b1 || q !== m_q[0].d) begin errors++; $display("FAIL b2b_out k=%0d: got ov %0b q %0h want 1 %0h", k, ov, q, m_q[0].d); end
      tick();
      checks++; if (occ !== 3'd4) begin errors++; $display("FAIL b2b_occ k=%0d: got %0d want 4", k, occ); end
    end
    iv = 1'b0;
    repeat (4) tick();
    checks++; if (occ !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", occ); end
    ordy = 1'b0;
  endtask

  task automatic test_midreset();
    ordy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv = 1'b1; a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      tick();
    end
    iv = 1'b0;
    checks++; if (occ !== 3'd3) begin errors++; $display("FAIL mrst_pre: got %0d want 3", occ); end
    res = 1'b1;
    tick();
    res = 1'b0;
    checks++; if (occ !== 3'd0 || ov !== 1'b0) begin errors++; $display("FAIL mrst_clear: got occ %0d ov %0b want 0 0", occ, ov); end
    ordy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mrst_ghost k=%0d: got ov %0b q %0h want 0", k, ov, q); end
    end
    ordy = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      res  = ($urandom_range(0, 39) == 0);
      iv   = 1'($urandom);
      ordy = 1'($urandom);
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      #1;
      checks++; if (ir !== m_ready()) begin errors++; $display("FAIL rnd_ir n=%0d: got %0b want %0b", n, ir, m_ready()); end
      checks++; if (ov !== m_valid()) begin errors++; $display("FAIL rnd_ov n=%0d: got %0b want %0b", n, ov, m_valid()); end
      checks++; if (occ !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_occ n=%0d: got %0d want %0d", n, occ, m_q.size()); end
      if (m_valid()) begin
        checks++; if (q !== m_q[0].d) begin errors++; $display("FAIL rnd_q n=%0d: got %0h want %0h", n, q, m_q[0].d); end
      end
      tick();
    end
    res = 1'b0; iv = 1'b0; ordy = 1'b1;
    repeat (6) tick();
    checks++; if (occ !== 3'd0 || ov !== 1'b0) begin errors++; $display("FAIL rnd_drain: got occ %0d ov %0b want 0 0", occ, ov); end
  endtask

  initial begin
    res = 1'b1;
    iv2 = 1'b0; a2 = '0; b2 = '0; op2 = '0; or2 = 1'b1;
    iv  = 1'b0; a  = '0; b  = '0; op  = '0; ordy = 1'b0;
    test_reset();
    test_ops();
    test_backpressure();
    test_bubble();
    test_back_to_back();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_pipe.md
# logic_pipe

Parametrised, handshaked two-operand logic pipeline. Each accepted input pair (a, b) is combined by a selectable bitwise operation and carried through DEPTH register stages to q. Per-stage valid bits, bubble collapsing and downstream backpressure make it a drop-in registered datapath stage for any valid/ready stream in the design.

## Interface
- WIDTH, 1: operand and result width in bits (>= 1).
- DEPTH, 2: number of register stages, equal to latency in cycles (>= 1).
- CW, $clog2(DEPTH+1): occupancy counter width (derived, not overridden).

- clk  input  1  clock; all state updates on the rising edge.
- res  input  1  reset; synchronous, active-high.
- in_valid  input  1  a, b, op hold a valid item this cycle.
- in_ready  output  1  pipeline accepts an item this cycle (combinational).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  operation for this item: 00 OR, 01 AND, 10 XOR, 11 pass-A.
- out_valid  output  1  q holds a valid result (registered).
- out_ready  input  1  consumer accepts q this cycle.
- q  output  WIDTH  result at the last stage (registered).
- occupancy  output  CW  number of valid stages (registered, 0..DEPTH).

## Operation
- Stage i (0..DEPTH-1) holds data_i[WIDTH-1:0] and v_i.
- Stage 0 loads op(a, b), computed combinationally from the current inputs, on acceptance. Stage i > 0 loads data_{i-1}.
- adv_{DEPTH-1} = out_ready. For i < DEPTH-1, adv_i = !v_{i+1} || adv_{i+1}. Stage i loads when !v_i || adv_i. Bubbles therefore collapse, and a stall propagates back only through occupied stages.
- in_ready = !v_0 || adv_0. An item is accepted when in_valid && in_ready.
- When stage 0 loads, v_0 takes the acceptance value. When stage i > 0 loads, v_i takes v_{i-1}. A stage that does not load holds both data and valid.
- Data registers load even when the incoming valid is 0. Data in an invalid stage is don't-care, except that after reset it is 0.
- q = data_{DEPTH-1}; out_valid = v_{DEPTH-1}.
- occupancy = occupancy + (item accepted) - (out_valid && out_ready), updated every cycle.
  - Must equal the population count of v at all times.
- Results are bitwise per lane. There is no carry and no width growth.
- Reset, including reset asserted mid-stream: every v_i, data_i, q, out_valid and occupancy is cleared to 0. In-flight items are discarded. While res is high, in_ready is 0 and no item is accepted.

## Timing
- Latency: an item accepted at edge k appears on q with out_valid=1 after edge k+DEPTH-1, when no stall occurs (with DEPTH=2 it is visible on the cycle after the edge k+1).
- Throughput: one item per cycle when out_ready is held high.
- Full pipeline (all v=1) with out_ready=0: in_ready=0, and all stages and q are held stable.
- Full pipeline with out_ready=1: output and input transfer on the same edge, occupancy is unchanged and in_ready=1.
- Empty pipeline: in_ready=1 regardless of out_ready.
- in_ready depends combinationally on out_ready. out_valid, q and occupancy are registered.
- Reset wins over any simultaneous handshake on the same edge.

## Test plan
- Reset: with res=1 for 2 cycles while driving in_valid=1, a=8'hFF, b=8'h0F -> out_valid=0, q=0, occupancy=0 and in_ready=0 throughout. After release, in_ready=1.
- Ops (WIDTH=8, DEPTH=2, out_ready=1): stream a=8'hCC, b=8'hAA with op 00,01,10,11 on consecutive cycles -> q=8'hEE, 8'h88, 8'h66, 8'hCC on four consecutive cycles, the first appearing 2 cycles after the first acceptance.
- Backpressure (DEPTH=4): drive in_valid=1 continuously with out_ready=0 -> exactly 4 items are accepted, then in_ready=0 and occupancy=4. Raise out_ready -> items emerge in order with none lost or duplicated.
- Bubble collapse (DEPTH=4): send 1 item, wait 2 cycles, send another, with out_ready=0 -> the second item advances until it sits directly behind the first, and occupancy=2.
- Simultaneous in/out: full pipeline with out_ready=1 and in_valid=1 -> one item out and one in per edge, occupancy stays at DEPTH.
- Mid-stream reset: pulse res for 1 cycle with occupancy=3 -> the next cycle shows occupancy=0 and out_valid=0, and no pre-reset item ever appears on q.
